prog_loader: RTL and testbench

Upstream boot stage for the pipelined MIPS datapath. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into the instruction memory write port at byte addresses 0, 4, 8, … and holds the core in reset until the whole image is in memory. It then releases the core so the PC starts fetching at address 0.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 138 +++++++++++++
 tb/tb_prog_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for prog_loader.
// master = stream source / memory observer, slave = the loader itself.
interface prog_loader_if;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        run;
  logic [1:0]  err;
  logic [15:0] words_loaded;

  modport master (
    output load_start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
           core_rst, run, err, words_loaded
  );

  modport slave (
    input  load_start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
           core_rst, run, err, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles a length-prefixed big-endian byte stream into imem words,
// holding the core in reset until loaded. Optional trailer XOR check: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_LOAD, S_CHECK, S_FIN, S_RUN, S_ERROR
  } state_t;

  state_t      r_state;
  logic        r_byte_ready;
  logic        r_core_rst;
  logic        r_run;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic [1:0]  r_err;
  logic [15:0] r_words_loaded;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [15:0] r_widx;
  logic [1:0]  r_bcnt;
  logic [23:0] r_shift;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  state_t      w_next;
  logic        w_hs;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_last;

  always_comb begin
    w_hs      = bus.byte_valid && r_byte_ready;
    w_len     = {r_len_hi, bus.byte_data};
    w_len_bad = (w_len == '0) || (32'(w_len) > DEPTH_WORDS);
    w_last    = (r_bcnt == 2'd3) && (r_widx == r_len - 16'd1);
    w_next    = r_state;
    if (bus.load_start) begin
      w_next = S_HDR_HI;
    end else begin
      case (r_state)
        S_HDR_HI: if (w_hs) w_next = S_HDR_LO;
        S_HDR_LO: if (w_hs) w_next = w_len_bad ? S_ERROR : S_LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
        S_LOAD:   if (w_hs && w_last) w_next = S_CHECK;
        S_CHECK:  if (w_hs) w_next = (bus.byte_data == r_csum) ? S_FIN : S_ERROR;
`else
        S_LOAD:   if (w_hs && w_last) w_next = S_FIN;
`endif
        S_FIN:    w_next = S_RUN;
        default:  w_next = r_state;
      endcase
    end
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_byte_ready   <= 1'b0;
      r_core_rst     <= 1'b1;
      r_run          <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_err          <= '0;
      r_words_loaded <= '0;
      r_len_hi       <= '0;
      r_len          <= '0;
      r_widx         <= '0;
      r_bcnt         <= '0;
      r_shift        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == S_HDR_HI) || (w_next == S_HDR_LO) ||
                      (w_next == S_LOAD)   || (w_next == S_CHECK);
      r_core_rst   <= (w_next != S_RUN);
      r_run        <= (w_next == S_RUN);
      r_imem_we    <= 1'b0;
      if (bus.load_start) begin
        r_widx         <= '0;
        r_bcnt         <= '0;
        r_words_loaded <= '0;
        r_err          <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_csum         <= '0;
`endif
      end else if (w_hs) begin
        case (r_state)
          S_HDR_HI: r_len_hi <= bus.byte_data;
          S_HDR_LO: begin
            r_len <= w_len;
            if (w_len_bad) r_err <= 2'd1;
          end
          S_LOAD: begin
            r_bcnt  <= r_bcnt + 2'd1;
            r_shift <= {r_shift[15:0], bus.byte_data};
            if (r_bcnt == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= {14'd0, r_widx, 2'b00};
              r_imem_wdata <= {r_shift, bus.byte_data};
              r_widx       <= r_widx + 16'd1;
              if (r_words_loaded < r_len) r_words_loaded <= r_words_loaded + 16'd1;
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CHECK: if (bus.byte_data != r_csum) r_err <= 2'd2;
`endif
          default: ;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        if ((r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_LOAD))
          r_csum <= r_csum ^ bus.byte_data;
`endif
      end
    end
  end

  assign bus.byte_ready   = r_byte_ready;
  assign bus.imem_we      = r_imem_we;
  assign bus.imem_addr    = r_imem_addr;
  assign bus.imem_wdata   = r_imem_wdata;
  assign bus.core_rst     = r_core_rst;
  assign bus.run          = r_run;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words_loaded;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (DEPTH_WORDS=64); honours PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.DEPTH_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  int          rviol = 0;
  logic [7:0]  x;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  // Write log and ready-legality monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end
    if (bus.byte_ready === 1'b1 && (bus.run !== 1'b0 || bus.err !== 2'd0)) rviol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    x = '0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("hs_wait", {31'd0, bus.byte_ready}, 32'd1);
    tick();
    bus.byte_valid = 1'b0;
    x = x ^ b;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gmax);
    logic [31:0] s;
    s = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(s[31:24], $urandom_range(0, gmax));
      s = s << 8;
    end
  endtask

  task automatic send_hdr(input logic [15:0] n, input int unsigned gmax);
    send_byte(n[15:8], $urandom_range(0, gmax));
    send_byte(n[7:0], $urandom_range(0, gmax));
  endtask

  task automatic finish_img();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] t;
    t = x;
    send_byte(t, 0);
`endif
  endtask

  task automatic chk_two_word(input string tag);
    chk({tag, "_run"}, {31'd0, bus.run}, 32'd1);
    chk({tag, "_core_rst"}, {31'd0, bus.core_rst}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({tag, "_words"}, {16'd0, bus.words_loaded}, 32'd2);
    chk({tag, "_nwr"}, wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'h0);
      chk({tag, "_d0"}, wd[0], 32'h20080005);
      chk({tag, "_a1"}, wa[1], 32'h4);
      chk({tag, "_d1"}, wd[1], 32'h8C090004);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    x = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("rst_run", {31'd0, bus.run}, 32'd0);
    chk("rst_err", {30'd0, bus.err}, 32'd0);
    chk("rst_words", {16'd0, bus.words_loaded}, 32'd0);
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    tick();
    chk("idle_ready", {31'd0, bus.byte_ready}, 32'd0);
    bus.byte_valid = 1'b0;

    // Two-word load
    start_load();
    chk("hdr_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_hdr(16'd2, 0);
    send_word(32'h20080005, 0);
    send_word(32'h8C090004, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("fin_we", {31'd0, bus.imem_we}, 32'd1);
    chk("fin_run", {31'd0, bus.run}, 32'd0);
    chk("fin_core_rst", {31'd0, bus.core_rst}, 32'd1);
`endif
    finish_img();
    tick();
    chk("run_we", {31'd0, bus.imem_we}, 32'd0);
    chk_two_word("load2");

    // Bad lengths and the largest legal length
    start_load();
    send_hdr(16'd0, 0);
    chk("len0_err", {30'd0, bus.err}, 32'd1);
    chk("len0_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("len0_run", {31'd0, bus.run}, 32'd0);
    chk("len0_core_rst", {31'd0, bus.core_rst}, 32'd1);
    tick();
    tick();
    chk("len0_nwr", wa.size(), 32'd0);
    start_load();
    chk("restart_err_clr", {30'd0, bus.err}, 32'd0);
    send_hdr(16'h0041, 0);
    chk("len65_err", {30'd0, bus.err}, 32'd1);
    chk("len65_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("len65_run", {31'd0, bus.run}, 32'd0);
    start_load();
    send_hdr(16'h0040, 0);
    chk("len64_err", {30'd0, bus.err}, 32'd0);
    chk("len64_ready", {31'd0, bus.byte_ready}, 32'd1);

    // Gaps in byte_valid
    start_load();
    send_hdr(16'd2, 3);
    send_word(32'h20080005, 3);
    send_word(32'h8C090004, 3);
    finish_img();
    tick();
    chk_two_word("gaps");

`ifdef PROG_LOADER_CHECKSUM_EN
    start_load();
    send_hdr(16'd2, 0);
    send_word(32'h20080005, 0);
    send_word(32'h8C090004, 0);
    send_byte(8'h00, 0);
    tick();
    chk("csum_err", {30'd0, bus.err}, 32'd2);
    chk("csum_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("csum_run", {31'd0, bus.run}, 32'd0);
    start_load();
    send_hdr(16'd2, 0);
    send_word(32'h20080005, 0);
    send_word(32'h8C090004, 0);
    finish_img();
    tick();
    chk_two_word("csum_ok");
`endif

    // Restart coinciding with a byte handshake
    start_load();
    send_hdr(16'd2, 0);
    send_word(32'h20080005, 0);
    send_byte(8'h8C, 0);
    chk("mid_words", {16'd0, bus.words_loaded}, 32'd1);
    bus.load_start = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    tick();
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    x = '0;
    wa.delete();
    wd.delete();
    chk("rs_words", {16'd0, bus.words_loaded}, 32'd0);
    chk("rs_ready", {31'd0, bus.byte_ready}, 32'd1);
    chk("rs_core_rst", {31'd0, bus.core_rst}, 32'd1);
    send_hdr(16'd1, 0);
    chk("rs_hdr_err", {30'd0, bus.err}, 32'd0);
    send_word(32'hDEADBEEF, 0);
    finish_img();
    tick();
    chk("rs_run", {31'd0, bus.run}, 32'd1);
    chk("rs_words1", {16'd0, bus.words_loaded}, 32'd1);
    chk("rs_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      chk("rs_a0", wa[0], 32'h0);
      chk("rs_d0", wd[0], 32'hDEADBEEF);
    end

    // Asynchronous reset between edges
    start_load();
    send_hdr(16'd2, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    chk("pre_rst_wdata", bus.imem_wdata, 32'h11223344);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("arst_wdata", bus.imem_wdata, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'd0);
    chk("arst_words", {16'd0, bus.words_loaded}, 32'd0);
    chk("arst_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("arst_run", {31'd0, bus.run}, 32'd0);
    chk("arst_err", {30'd0, bus.err}, 32'd0);
    tick();
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h00;
    tick();
    tick();
    chk("arst_idle_ready", {31'd0, bus.byte_ready}, 32'd0);
    bus.byte_valid = 1'b0;

    chk("ready_legal", rviol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
